// File: rtl/la_seq_pkg.sv
// la_seq_checker shared types and field positions.
// State encoding, LA control bit indices, status layout.
package la_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int START   = 0;
  localparam int MODE    = 1;
  localparam int CLEAR   = 2;
  localparam int STROBE  = 3;
  localparam int RB_SEL  = 4;
  localparam int LEN_LSB = 8;
  localparam int LEN_MSB = 23;
  localparam int SMP_LSB = 32;
  localparam int SMP_MSB = 63;

  localparam int ST_ERR   = 0;
  localparam int ST_STATE = 16;
  localparam int ST_PASS  = 18;
  localparam int ST_SAT   = 19;

endpackage

// File: rtl/la_seq_gen.sv
// Expected-sample generator: counter or Galois LFSR.
// Load restores SEED and wins over advance.
module la_seq_gen #(
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic        mode,
  output logic [31:0] value
);

  logic [31:0] lfsr_nxt;

  assign lfsr_nxt = (value >> 1) ^
                    (value[0] ? LFSR_TAPS : 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= mode ? lfsr_nxt : value + 32'd1;
    end
  end

endmodule

// File: rtl/la_seq_checker.sv
// Self-checking LA sample consumer: compares strobed samples
// against an expected sequence and reports on LA banks 2/3.
module la_seq_checker
  import la_seq_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter logic [31:0] LFSR_TAPS = 32'h8020_0003,
  parameter int          ERR_W     = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  output logic [127:0] la_data_out,
  input  logic [127:0] la_oenb
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [63:0]      in_q;
  logic             start_q;
  logic             strb_q;
  state_t           state;
  logic             mode_q;
  logic [15:0]      len_q;
  logic [15:0]      cnt;
  logic [15:0]      first_idx;
  logic [ERR_W-1:0] err;
  logic             sat;
  logic [31:0]      exp_val;

  logic        clr;
  logic        start_ev;
  logic        strobe_ev;
  logic        run_ev;
  logic        mism;
  logic [15:0] cnt_nxt;
  logic [15:0] len_in;
  logic [15:0] err16;
  logic [31:0] status;
  logic [31:0] rdback;
  logic        unused_bits;

  assign clr       = in_q[CLEAR];
  assign start_ev  = in_q[START] & ~start_q;
  assign strobe_ev = in_q[STROBE] ^ strb_q;
  assign run_ev    = (state == RUN) & strobe_ev
                   & ~clr & ~start_ev;
  assign mism      = in_q[SMP_MSB:SMP_LSB] != exp_val;
  assign cnt_nxt   = cnt + 16'd1;
  assign len_in    = in_q[LEN_MSB:LEN_LSB];

  assign unused_bits = ^{la_data_in[127:64],
                         in_q[31:24], in_q[7:5]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      in_q    <= '0;
      start_q <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      in_q    <= la_data_in[63:0];
      start_q <= in_q[START];
      strb_q  <= in_q[STROBE];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      first_idx <= 16'hFFFF;
      err       <= '0;
      sat       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      first_idx <= 16'hFFFF;
      err       <= '0;
      sat       <= 1'b0;
    end else if (start_ev) begin
      state     <= (len_in == 16'd0) ? DONE : RUN;
      mode_q    <= in_q[MODE];
      len_q     <= len_in;
      cnt       <= '0;
      first_idx <= 16'hFFFF;
      err       <= '0;
      sat       <= 1'b0;
    end else if (run_ev) begin
      if (mism) begin
        if (err == ERR_MAX) sat <= 1'b1;
        else err <= err + 1'b1;
        if (first_idx == 16'hFFFF) first_idx <= cnt;
      end
      cnt <= cnt_nxt;
      if (cnt_nxt == len_q) state <= DONE;
    end
  end

  la_seq_gen #(
    .SEED      (SEED),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_gen (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (clr | start_ev),
    .advance (run_ev),
    .mode    (mode_q),
    .value   (exp_val)
  );

  always_comb begin
    err16 = '0;
    err16[ERR_W-1:0] = err;
    status = '0;
    status[ST_ERR+:16]  = err16;
    status[ST_STATE+:2] = state;
    status[ST_PASS]     = (state == DONE) && (err == '0);
    status[ST_SAT]      = sat;
  end

  assign rdback = in_q[RB_SEL] ? {first_idx, cnt} : exp_val;

  assign la_data_out = {rdback, status, 64'h0} & la_oenb;

endmodule
